// File: rtl/conv55_sched.sv
// Frame scheduler for a combinational 5x5 convolution unit: builds sliding
// windows from a raster pixel stream and registers the unit's result on a valid/ready stream.
module conv55_sched #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     filt_wr,
    input  logic [BIT_WIDTH-1:0]     filt_data,
    output logic                     filt_loaded,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BIT_WIDTH-1:0]     in_pixel,
    output logic [25*BIT_WIDTH-1:0]  win_feature,
    output logic [25*BIT_WIDTH-1:0]  win_filter,
    input  logic [OUT_WIDTH-1:0]     conv_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state, state_nxt;
    logic                 done_nxt;
    logic [4:0]           filt_cnt;
    logic [BIT_WIDTH-1:0] taps [25];
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [BIT_WIDTH-1:0] lb0 [IMG_W];
    logic [BIT_WIDTH-1:0] lb1 [IMG_W];
    logic [BIT_WIDTH-1:0] lb2 [IMG_W];
    logic [BIT_WIDTH-1:0] lb3 [IMG_W];
    logic [BIT_WIDTH-1:0] win [5][5];
    logic [BIT_WIDTH-1:0] newcol [5];
    logic                 win_vld, accept, capture, last_px, qualify, go;

    assign go       = (state == IDLE) && start && filt_loaded;
    assign capture  = win_vld && (!out_valid || out_ready);
    assign in_ready = (state == RUN) && (!win_vld || capture);
    assign accept   = in_valid && in_ready;
    assign last_px  = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign qualify  = (row >= RW'(4)) && (col >= CW'(4));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE:  if (go) state_nxt = RUN;
            RUN:   if (accept && last_px) state_nxt = DRAIN;
            DRAIN: if (!win_vld && !out_valid) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // A write after a complete load restarts the sequence at tap 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt    <= '0;
            filt_loaded <= 1'b0;
            for (int i = 0; i < 25; i++) taps[i] <= '0;
        end else if (state == IDLE && filt_wr) begin
            if (filt_loaded) begin
                taps[0]     <= filt_data;
                filt_cnt    <= 5'd1;
                filt_loaded <= 1'b0;
            end else begin
                taps[filt_cnt] <= filt_data;
                if (filt_cnt == 5'd24) begin
                    filt_cnt    <= '0;
                    filt_loaded <= 1'b1;
                end else begin
                    filt_cnt <= filt_cnt + 5'd1;
                end
            end
        end
    end

    always_comb begin
        newcol[0] = lb0[col];
        newcol[1] = lb1[col];
        newcol[2] = lb2[col];
        newcol[3] = lb3[col];
        newcol[4] = in_pixel;
    end

    // Line buffers hold only pixel history; validity comes from the row/col qualification.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col] <= lb1[col];
            lb1[col] <= lb2[col];
            lb2[col] <= lb3[col];
            lb3[col] <= in_pixel;
        end
    end

    // Stage p0: window shift on pixel accept; stage p1: result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row       <= '0;
            col       <= '0;
            win_vld   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) win[r][c] <= '0;
        end else begin
            if (go) begin
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (accept) begin
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 4; c++) win[r][c] <= win[r][c+1];
                    win[r][4] <= newcol[r];
                end
            end
            if (accept && qualify) win_vld <= 1'b1;
            else if (capture)      win_vld <= 1'b0;
            if (capture) begin
                out_data  <= conv_value;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        win_feature = '0;
        win_filter  = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_feature[(5*r+4-c)*BIT_WIDTH +: BIT_WIDTH] = win[r][c];
                win_filter[(5*r+c)*BIT_WIDTH +: BIT_WIDTH]    = taps[5*r+c];
            end
        end
    end
endmodule

// File: tb/tb_conv55_sched.sv
// Directed bench for conv55_sched on an 8x6 frame with a behavioural 5x5 conv unit.
module tb_conv55_sched;
    localparam int BW = 8;
    localparam int OW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0, filt_wr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [BW-1:0]   filt_data = '0, in_pixel = '0;
    logic            filt_loaded, in_ready, out_valid, busy, done;
    logic [25*BW-1:0] win_feature, win_filter;
    logic [OW-1:0]   conv_value, out_data;

    conv55_sched #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .IMG_W(8), .IMG_H(6)) dut (
        .clk(clk), .rst(rst), .start(start), .filt_wr(filt_wr), .filt_data(filt_data),
        .filt_loaded(filt_loaded), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .win_feature(win_feature), .win_filter(win_filter),
        .conv_value(conv_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Conv unit: feature (r,c) at slot 5r+4-c, filter (r,c) at slot 5r+c.
    always_comb begin
        logic [31:0] acc;
        acc = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                acc = acc + 32'(win_feature[(5*r+4-c)*BW +: BW]) * 32'(win_filter[(5*r+c)*BW +: BW]);
        conv_value = acc;
    end

    typedef struct packed {
        logic             ones;
        logic [7:0]       tap_sel;
        logic             rnd;
        logic [7:0][31:0] exp;
    } vec_t;

    vec_t  vecs [7];
    int    n_cmp = 0, n_fail = 0;
    int    cyc = 0, acc_cyc = -1, first_ov = -1;
    int    done_cnt = 0, busy_bad = 0, stall_bad = 0;
    bit    rnd_mode = 0, abort = 0;
    logic [31:0] got [$];

    function automatic logic [7:0][31:0] mk(input int a, b, c, d, e, f, g, h);
        logic [7:0][31:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e; v[5] = f; v[6] = g; v[7] = h;
        return v;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1 out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (out_valid && out_ready) got.push_back(out_data);
        if (done) begin
            done_cnt++;
            if (busy) busy_bad++;
        end
        if (dut.win_vld && out_valid && !out_ready && in_ready) stall_bad++;
    end

    task automatic load_filter(input bit ones, input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            filt_wr = 1'b1;
            filt_data = ones ? 8'd1 : ((i == sel) ? 8'd1 : 8'd0);
            @(posedge clk); #1;
        end
        filt_wr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_px(input logic [7:0] v, input bit mark);
        int  t = 0;
        bit  ok = 0;
        in_valid = 1'b1;
        in_pixel = v;
        while (!ok && t < 100) begin
            @(negedge clk);
            if (in_ready) begin
                if (mark) acc_cyc = cyc;
                @(posedge clk); #1;
                ok = 1;
            end
            t++;
        end
        if (!ok) begin
            check("pixel_accept_timeout", 0, 1);
            abort = 1;
        end
    endtask

    task automatic feed(input bit ones, input int npix);
        for (int i = 0; i < npix && !abort; i++)
            drive_px(ones ? 8'd1 : 8'(i), i == 4*8+4);
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        got.delete();
        done_cnt = 0; busy_bad = 0; stall_bad = 0; first_ov = -1; acc_cyc = -1; abort = 0;
    endtask

    task automatic check_frame(input string nm, input logic [7:0][31:0] exp);
        check({nm, "_count"}, got.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_out%0d", nm, i), (i < got.size()) ? got[i] : -1, exp[i]);
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_done_busy_overlap"}, busy_bad, 0);
        check({nm, "_stall_in_ready"}, stall_bad, 0);
    endtask

    task automatic run_vec(input int k);
        vec_t v = vecs[k];
        clear_mon();
        load_filter(v.ones, int'(v.tap_sel), 25);
        check($sformatf("v%0d_filt_loaded", k), filt_loaded, 1);
        rnd_mode = v.rnd;
        do_start();
        check($sformatf("v%0d_busy", k), busy, 1);
        feed(v.ones, 48);
        wait_done();
        rnd_mode = 0;
        check_frame($sformatf("v%0d", k), v.exp);
    endtask

    initial begin
        vecs[0] = '{ones: 1'b1, tap_sel: 8'd0,  rnd: 1'b0, exp: mk(25, 25, 25, 25, 25, 25, 25, 25)};
        vecs[1] = '{ones: 1'b0, tap_sel: 8'd12, rnd: 1'b0, exp: mk(18, 19, 20, 21, 26, 27, 28, 29)};
        vecs[2] = '{ones: 1'b0, tap_sel: 8'd0,  rnd: 1'b0, exp: mk(0, 1, 2, 3, 8, 9, 10, 11)};
        vecs[3] = '{ones: 1'b0, tap_sel: 8'd12, rnd: 1'b1, exp: mk(18, 19, 20, 21, 26, 27, 28, 29)};
        vecs[4] = '{ones: 1'b0, tap_sel: 8'd24, rnd: 1'b0, exp: mk(36, 37, 38, 39, 44, 45, 46, 47)};
        vecs[5] = '{ones: 1'b0, tap_sel: 8'd4,  rnd: 1'b1, exp: mk(4, 5, 6, 7, 12, 13, 14, 15)};
        vecs[6] = '{ones: 1'b0, tap_sel: 8'd20, rnd: 1'b1, exp: mk(32, 33, 34, 35, 40, 41, 42, 43)};

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_filt_loaded", filt_loaded, 0);
        check("rst_win_feature_zero", win_feature == '0, 1);
        check("rst_win_filter_zero", win_filter == '0, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            run_vec(k);
            if (k == 0) check("latency_px44_to_out_valid", first_ov - acc_cyc, 2);
        end

        // Incomplete filter load, start coinciding with the final write, writes during RUN.
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        clear_mon();
        load_filter(1'b0, 12, 24);
        check("tap24_filt_loaded", filt_loaded, 0);
        do_start();
        repeat (3) @(posedge clk);
        #1;
        check("tap24_start_busy", busy, 0);
        check("tap24_start_in_ready", in_ready, 0);
        filt_wr = 1'b1; filt_data = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        filt_wr = 1'b0; start = 1'b0;
        check("tap25_filt_loaded", filt_loaded, 1);
        check("start_with_last_wr_busy", busy, 0);
        do_start();
        check("tap25_start_busy", busy, 1);
        filt_wr = 1'b1; filt_data = 8'hFF;
        feed(1'b0, 48);
        filt_wr = 1'b0;
        wait_done();
        check("run_wr_filt_loaded", filt_loaded, 1);
        check_frame("wr_in_run", vecs[1].exp);

        // Asynchronous reset in the middle of row 5.
        clear_mon();
        load_filter(1'b0, 12, 25);
        do_start();
        feed(1'b0, 5*8+3);
        check("pre_rst_out_data_nonzero", out_data != '0, 1);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_filt_loaded", filt_loaded, 0);
        check("mid_rst_win_feature_zero", win_feature == '0, 1);
        check("mid_rst_win_filter_zero", win_filter == '0, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        run_vec(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
